// File: rtl/d_latch_pkg.sv
// Shared types and constants for the D-latch exerciser and its LFSR.
package d_latch_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DRAW,
        ST_WAIT_EN,
        ST_TOGGLE,
        ST_WAIT_D,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam int         DELAY_W       = 3;
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

    // An all-zero LFSR never leaves zero, so a zero seed is swapped out.
    function automatic logic [7:0] fix_seed(input logic [7:0] seed);
        return (seed == 8'h00) ? ZERO_SEED_SUB : seed;
    endfunction

endpackage

// File: rtl/d_latch_exerciser_lfsr8.sv
// 8-bit right-shifting Galois LFSR (x^8+x^6+x^5+x^4+1) with load and step.
module lfsr8
    import d_latch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_seed,
    input  logic       i_load,
    input  logic       i_step,
    output logic [7:0] o_value
);

    logic [7:0] r_lfsr;
    logic [7:0] w_next;

    assign w_next  = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 8'h00);
    assign o_value = r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= i_seed;
        end else if (i_load) begin
            r_lfsr <= fix_seed(i_seed);
        end else if (i_step) begin
            r_lfsr <= w_next;
        end
    end

endmodule

// File: rtl/d_latch_exerciser.sv
// Drives a D latch through randomised enable/data timing and counts q
// disagreements against an internal transparent-latch model.
module d_latch_exerciser
    import d_latch_pkg::*;
#(
    parameter int         ITER_COUNT = 5,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       d_out,
    output logic       enable_out,
    output logic       latch_clr,
    input  logic       q_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] mismatch_count,
    output logic [7:0] iter
);

    localparam logic [7:0] LAST_ITER = 8'(ITER_COUNT - 1);

    state_t             r_state;
    logic [DELAY_W-1:0] r_cnt;
    logic [DELAY_W-1:0] r_delay1;
    logic               r_d;
    logic               r_en;
    logic               r_exp_q;
    logic [7:0]         r_mm;
    logic [7:0]         r_iter;

    logic [7:0]         w_lfsr;
    logic [DELAY_W-1:0] w_draw_d1;
    logic [DELAY_W-1:0] w_draw_d2;
    logic               w_unused_lfsr;

    assign w_draw_d1     = w_lfsr[2:0];
    assign w_draw_d2     = w_lfsr[5:3];
    assign w_unused_lfsr = ^w_lfsr[7:6];

    lfsr8 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .i_seed  (LFSR_SEED),
        .i_load  (r_state == ST_CLEAR),
        .i_step  (r_state == ST_DRAW),
        .o_value (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_delay1 <= '0;
            r_d      <= 1'b0;
            r_en     <= 1'b0;
            r_exp_q  <= 1'b0;
            r_mm     <= 8'd0;
            r_iter   <= 8'd0;
        end else begin
            // Reference latch: transparent whenever the driven enable is high.
            if (r_en) begin
                r_exp_q <= r_d;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_d     <= 1'b0;
                    r_en    <= 1'b0;
                    r_exp_q <= 1'b0;
                    r_iter  <= 8'd0;
                    r_mm    <= 8'd0;
                    r_state <= (ITER_COUNT == 0) ? ST_DONE : ST_DRAW;
                end
                ST_DRAW: begin
                    // A zero delay skips its wait state entirely.
                    r_cnt    <= w_draw_d2;
                    r_delay1 <= w_draw_d1;
                    r_state  <= (w_draw_d2 == '0) ? ST_TOGGLE : ST_WAIT_EN;
                end
                ST_WAIT_EN: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == DELAY_W'(1)) begin
                        r_state <= ST_TOGGLE;
                    end
                end
                ST_TOGGLE: begin
                    r_en    <= ~r_en;
                    r_cnt   <= r_delay1;
                    r_state <= (r_delay1 == '0) ? ST_DRIVE : ST_WAIT_D;
                end
                ST_WAIT_D: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == DELAY_W'(1)) begin
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    r_d     <= r_iter[0];
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if ((q_in != r_exp_q) && (r_mm != 8'hFF)) begin
                        r_mm <= r_mm + 8'd1;
                    end
                    if (r_iter == LAST_ITER) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_iter  <= r_iter + 8'd1;
                        r_state <= ST_DRAW;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign d_out          = r_d;
    assign enable_out     = r_en;
    assign latch_clr      = (r_state == ST_CLEAR);
    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_DONE);
    assign mismatch_count = r_mm;
    assign iter           = r_iter;

endmodule

// File: tb/tb_d_latch_exerciser.sv
// Bench for d_latch_exerciser: four instances cover the main run, a zero-length
// run, and zero/one seeds with stuck-at-1 q for the 255-iteration case.
module tb_d_latch_exerciser;

    localparam int W = 26;
    localparam int N = 4;
    localparam int A = 0;
    localparam int Z = 1;
    localparam int S0 = 2;
    localparam int S1 = 3;
    // Seed A5, 5 iterations: (d1,d2) = (5,4),(2,5),(5,6),(2,0),(1,0) -> 55 + 2.
    localparam int CYC_A = 57;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [N-1:0] start_v;
    logic [1:0]   q_mode;
    logic         lat_q;
    wire  [N-1:0] q_v;
    wire  [N-1:0] d_v;
    wire  [N-1:0] en_v;
    wire  [N-1:0] clr_v;
    wire  [N-1:0] busy_v;
    wire  [N-1:0] done_v;
    wire  [7:0]   mm_v [N];
    wire  [7:0]   it_v [N];

    logic [W-1:0] exp_q [N][$];
    int n_checks = 0;
    int n_errors = 0;
    int bc [N];

    // Ideal latch for instance A; q_mode 1/2 force stuck-at-1/0.
    always_latch begin
        if (clr_v[A]) lat_q <= 1'b0;
        else if (en_v[A]) lat_q <= d_v[A];
    end

    assign q_v[A]  = (q_mode == 2'd0) ? lat_q : (q_mode == 2'd1);
    assign q_v[Z]  = 1'b0;
    assign q_v[S0] = 1'b1;
    assign q_v[S1] = 1'b1;

    d_latch_exerciser #(.ITER_COUNT(5), .LFSR_SEED(8'hA5)) u_a (
        .clk(clk), .reset(reset), .start(start_v[A]), .d_out(d_v[A]),
        .enable_out(en_v[A]), .latch_clr(clr_v[A]), .q_in(q_v[A]),
        .busy(busy_v[A]), .done(done_v[A]), .mismatch_count(mm_v[A]), .iter(it_v[A])
    );

    d_latch_exerciser #(.ITER_COUNT(0), .LFSR_SEED(8'hA5)) u_z (
        .clk(clk), .reset(reset), .start(start_v[Z]), .d_out(d_v[Z]),
        .enable_out(en_v[Z]), .latch_clr(clr_v[Z]), .q_in(q_v[Z]),
        .busy(busy_v[Z]), .done(done_v[Z]), .mismatch_count(mm_v[Z]), .iter(it_v[Z])
    );

    d_latch_exerciser #(.ITER_COUNT(255), .LFSR_SEED(8'h00)) u_s0 (
        .clk(clk), .reset(reset), .start(start_v[S0]), .d_out(d_v[S0]),
        .enable_out(en_v[S0]), .latch_clr(clr_v[S0]), .q_in(q_v[S0]),
        .busy(busy_v[S0]), .done(done_v[S0]), .mismatch_count(mm_v[S0]), .iter(it_v[S0])
    );

    d_latch_exerciser #(.ITER_COUNT(255), .LFSR_SEED(8'h01)) u_s1 (
        .clk(clk), .reset(reset), .start(start_v[S1]), .d_out(d_v[S1]),
        .enable_out(en_v[S1]), .latch_clr(clr_v[S1]), .q_in(q_v[S1]),
        .busy(busy_v[S1]), .done(done_v[S1]), .mismatch_count(mm_v[S1]), .iter(it_v[S1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [7:0] mm, input int cyc,
                                          input logic en, input logic d);
        return {mm, cyc[15:0], en, d};
    endfunction

    function automatic int run_cycles(input logic [7:0] seed, input int n);
        logic [7:0] l;
        int c;
        l = (seed == 8'h00) ? 8'h01 : seed;
        c = 2;
        for (int i = 0; i < n; i++) begin
            c += 5 + int'(l[2:0]) + int'(l[5:3]);
            l = {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
        end
        return c;
    endfunction

    // Monitor: measures busy length and pops one expectation per done pulse.
    initial begin
        logic [W-1:0] e;
        for (int g = 0; g < N; g++) bc[g] = 0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < N; g++) begin
                if (busy_v[g]) bc[g]++;
                else bc[g] = 0;
                if (done_v[g]) begin
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("unexpected_done_%0d", g), 32'd1, 32'd0);
                    end else begin
                        e = exp_q[g].pop_front();
                        check($sformatf("mismatch_count_%0d", g), mm_v[g], e[25:18]);
                        check($sformatf("busy_cycles_%0d", g), bc[g], e[17:2]);
                        check($sformatf("enable_end_%0d", g), en_v[g], e[1]);
                        check($sformatf("d_end_%0d", g), d_v[g], e[0]);
                    end
                end
            end
        end
    end

    task automatic pulse_start(input logic [N-1:0] m);
        start_v = m;
        @(negedge clk);
        start_v = '0;
    endtask

    task automatic wait_done(input int g, input int budget, input string name);
        int k;
        k = 0;
        while (done_v[g] !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done_seen"}, (k < budget), 32'd1);
    endtask

    initial begin
        int k;
        reset   = 1'b1;
        start_v = '0;
        q_mode  = 2'd0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) begin
            check($sformatf("rst_d_%0d", g), d_v[g], 32'd0);
            check($sformatf("rst_en_%0d", g), en_v[g], 32'd0);
            check($sformatf("rst_clr_%0d", g), clr_v[g], 32'd0);
            check($sformatf("rst_busy_%0d", g), busy_v[g], 32'd0);
            check($sformatf("rst_done_%0d", g), done_v[g], 32'd0);
            check($sformatf("rst_mm_%0d", g), mm_v[g], 32'd0);
            check($sformatf("rst_iter_%0d", g), it_v[g], 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Ideal latch run.
        exp_q[A].push_back(pack(8'd0, CYC_A, 1'b1, 1'b0));
        pulse_start(4'b0001);
        check("s1_clr", clr_v[A], 32'd1);
        check("s1_busy", busy_v[A], 32'd1);
        wait_done(A, 200, "s1");
        @(negedge clk);
        check("s1_idle", busy_v[A], 32'd0);

        // Stuck-at-1 then stuck-at-0 q.
        q_mode = 2'd1;
        exp_q[A].push_back(pack(8'd5, CYC_A, 1'b1, 1'b0));
        pulse_start(4'b0001);
        wait_done(A, 200, "s2_q1");
        repeat (3) @(negedge clk);
        check("s2_mm_held", mm_v[A], 32'd5);
        check("s2_en_held", en_v[A], 32'd1);
        q_mode = 2'd2;
        exp_q[A].push_back(pack(8'd0, CYC_A, 1'b1, 1'b0));
        pulse_start(4'b0001);
        wait_done(A, 200, "s2_q0");
        @(negedge clk);

        // Reset during WAIT_D of iteration 2 (enable has just risen).
        q_mode = 2'd0;
        pulse_start(4'b0001);
        k = 0;
        while (!(it_v[A] == 8'd2 && en_v[A] == 1'b1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("s3_reached_iter2", (k < 200), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("s3_d", d_v[A], 32'd0);
        check("s3_en", en_v[A], 32'd0);
        check("s3_clr", clr_v[A], 32'd0);
        check("s3_busy", busy_v[A], 32'd0);
        check("s3_done", done_v[A], 32'd0);
        check("s3_mm", mm_v[A], 32'd0);
        check("s3_iter", it_v[A], 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("s3_still_idle", busy_v[A], 32'd0);
        exp_q[A].push_back(pack(8'd0, CYC_A, 1'b1, 1'b0));
        pulse_start(4'b0001);
        wait_done(A, 200, "s3_rerun");
        @(negedge clk);

        // Zero-iteration run: one clear cycle, then done.
        exp_q[Z].push_back(pack(8'd0, 2, 1'b0, 1'b0));
        pulse_start(4'b0010);
        check("s4_clr", clr_v[Z], 32'd1);
        check("s4_no_done_yet", done_v[Z], 32'd0);
        @(negedge clk);
        check("s4_clr_off", clr_v[Z], 32'd0);
        check("s4_done", done_v[Z], 32'd1);
        @(negedge clk);
        check("s4_idle", busy_v[Z], 32'd0);

        // Start held high across a run: second run only after IDLE.
        exp_q[A].push_back(pack(8'd0, CYC_A, 1'b1, 1'b0));
        exp_q[A].push_back(pack(8'd0, CYC_A, 1'b1, 1'b0));
        start_v[A] = 1'b1;
        @(negedge clk);
        wait_done(A, 200, "s5_first");
        @(negedge clk);
        check("s5_gap_busy", busy_v[A], 32'd0);
        check("s5_gap_clr", clr_v[A], 32'd0);
        @(negedge clk);
        check("s5_second_clr", clr_v[A], 32'd1);
        start_v[A] = 1'b0;
        wait_done(A, 200, "s5_second");
        @(negedge clk);

        // Seeds 0 and 1 must match; 255 stuck-at-1 checks reach 255.
        exp_q[S0].push_back(pack(8'd255, run_cycles(8'h01, 255), 1'b1, 1'b0));
        exp_q[S1].push_back(pack(8'd255, run_cycles(8'h01, 255), 1'b1, 1'b0));
        pulse_start(4'b1100);
        wait_done(S0, 6000, "s6");
        check("s6_same_cycle", done_v[S1], 32'd1);
        repeat (2) @(negedge clk);

        for (int g = 0; g < N; g++) begin
            check($sformatf("queue_empty_%0d", g), exp_q[g].size(), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
